// File: rtl/result_mem_writer.sv
// Write side of the result frame memory: takes a valid/ready pixel stream and writes
// one pixel per word at sequential addresses, framed by a start/busy/done FSM.
module result_mem_writer #(
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 640,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              pix_eol,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              line_err,
  output logic [9:0]        row,
  output logic [9:0]        col
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [9:0]        COL_LAST   = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]        ROW_LAST   = 10'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_t              state_r;
  state_t              next_s;
  logic                pix_ready_r;
  logic                busy_r;
  logic                done_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [9:0]          row_r;
  logic [9:0]          col_r;
  logic                line_err_r;
  logic                xfer_s;
  logic                col_last_s;
  logic                row_last_s;
  logic                frame_start_s;

  assign xfer_s        = pix_valid & pix_ready_r;
  assign col_last_s    = (col_r == COL_LAST);
  assign row_last_s    = (row_r == ROW_LAST);
  assign frame_start_s = (state_r == S_IDLE) & start;

  // Next-state decode for the frame FSM
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_s = S_RUN;
        else       next_s = S_IDLE;
      end
      S_RUN: begin
        if (xfer_s && row_last_s && col_last_s) next_s = S_LAST;
        else                                    next_s = S_RUN;
      end
      S_LAST:  next_s = S_DONE;
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State register with status outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pix_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= next_s;
      pix_ready_r <= (next_s == S_RUN);
      busy_r      <= (next_s == S_RUN) || (next_s == S_LAST);
      done_r      <= (next_s == S_DONE);
    end
  end

  // Write port, frame counters and sticky line-alignment error
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      addr_r      <= '0;
      row_r       <= 10'd0;
      col_r       <= 10'd0;
      line_err_r  <= 1'b0;
    end else begin
      mem_we_r <= xfer_s;
      if (frame_start_s) begin
        addr_r     <= '0;
        row_r      <= 10'd0;
        col_r      <= 10'd0;
        line_err_r <= 1'b0;
      end else if (xfer_s) begin
        mem_addr_r  <= addr_r;
        mem_wdata_r <= {{(DATA_W-8){1'b0}}, pix_data};
        // Saturate at the last word so the address can never leave the frame
        if (addr_r != FRAME_LAST) addr_r <= addr_r + ADDR_ONE;
        if (col_last_s) begin
          col_r <= 10'd0;
          row_r <= row_r + 10'd1;
        end else begin
          col_r <= col_r + 10'd1;
        end
        if (pix_eol != col_last_s) line_err_r <= 1'b1;
      end
    end
  end

  assign pix_ready = pix_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign line_err  = line_err_r;
  assign row       = row_r;
  assign col       = col_r;

endmodule

// File: tb/tb_result_mem_writer.sv
// Scoreboard bench for result_mem_writer on a 4x3 frame: expected writes are queued
// as pixels are accepted and matched against each mem_we cycle.
module tb_result_mem_writer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 19;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_eol;
  logic          pix_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          line_err;
  logic [9:0]    row;
  logic [9:0]    col;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  exp_addr;
  int  wr_cnt;
  int  done_cnt;
  int  total;
  int  bad;

  result_mem_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_eol(pix_eol), .pix_ready(pix_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .line_err(line_err),
    .row(row), .col(col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; every write the DUT issues is matched against the scoreboard head
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (done) done_cnt++;
    if (mem_we) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          bad++;
          $display("FAIL write_check: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic eol, input logic st);
    int  n;
    wr_t e;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_eol   = eol;
    start     = st;
    while (!pix_ready && n < 20) begin
      step();
      start = 1'b0;
      n++;
    end
    total++;
    if (!pix_ready) begin
      bad++;
      $display("FAIL send_timeout: got pix_ready=%b, expected 1 within 20 cycles", pix_ready);
    end else begin
      e.addr = AW'(exp_addr);
      e.data = {24'h000000, d};
      exp_q.push_back(e);
      exp_addr++;
      step();
    end
    pix_valid = 1'b0;
    pix_eol   = 1'b0;
    start     = 1'b0;
  endtask

  task automatic do_start(input logic with_valid);
    start     = 1'b1;
    pix_valid = with_valid;
    pix_data  = 8'hEE;
    pix_eol   = 1'b0;
    step();
    start     = 1'b0;
    pix_valid = 1'b0;
    exp_addr  = 0;
    wr_cnt    = 0;
    done_cnt  = 0;
    total++;
    if (pix_ready !== 1'b1 || busy !== 1'b1 || line_err !== 1'b0 || row !== 10'd0 ||
        col !== 10'd0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL start_state: got ready=%b busy=%b err=%b row=%0d col=%0d we=%b, expected 1 1 0 0 0 0",
               pix_ready, busy, line_err, row, col, mem_we);
    end
  endtask

  task automatic run_frame(input logic gap, input int err_idx, input int run_start_idx,
                           input logic done_start, input logic exp_err);
    logic eol;
    for (int i = 0; i < W * H; i++) begin
      if (i == W * H - 1) begin
        total++;
        if (row !== 10'(H - 1) || col !== 10'(W - 1)) begin
          bad++;
          $display("FAIL final_pos: got row=%0d col=%0d, expected row=%0d col=%0d", row, col, H - 1, W - 1);
        end
      end
      eol = ((i % W) == W - 1) || (i == err_idx);
      send(8'(8'h10 + i), eol, (i == run_start_idx));
      if (i == err_idx - 1 || i == err_idx) begin
        total++;
        if (line_err !== (i == err_idx)) begin
          bad++;
          $display("FAIL line_err_edge: got %b at pixel %0d, expected %b", line_err, i, (i == err_idx));
        end
      end
      if (gap && i < W * H - 1) step();
    end
    total++;
    if (pix_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL last_state: got ready=%b busy=%b done=%b, expected 0 1 0", pix_ready, busy, done);
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_state: got done=%b busy=%b ready=%b, expected 1 0 0", done, busy, pix_ready);
    end
    start = done_start;
    step();
    start = 1'b0;
    step();
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after: got done=%b busy=%b ready=%b, expected 0 0 0", done, busy, pix_ready);
    end
    total++;
    if (wr_cnt !== W * H || done_cnt !== 1 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL frame_counts: got writes=%0d dones=%0d pending=%0d, expected %0d 1 0",
               wr_cnt, done_cnt, exp_q.size(), W * H);
    end
    total++;
    if (line_err !== exp_err) begin
      bad++;
      $display("FAIL line_err_final: got %b, expected %b", line_err, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if (pix_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || line_err !== 1'b0 || row !== 10'd0 || col !== 10'd0) begin
      bad++;
      $display("FAIL reset_values: got ready=%b we=%b addr=%0d wdata=%h busy=%b done=%b err=%b row=%0d col=%0d, expected all 0",
               pix_ready, mem_we, mem_addr, mem_wdata, busy, done, line_err, row, col);
    end
    pix_valid = 1'b1;
    pix_data  = 8'h55;
    for (int i = 0; i < 3; i++) step();
    pix_valid = 1'b0;
    total++;
    if (pix_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_ready: got ready=%b busy=%b, expected 0 0", pix_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_start(1'b0);
    run_frame(1'b0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_valid_toggle();
    do_start(1'b0);
    run_frame(1'b1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_line_err();
    do_start(1'b0);
    run_frame(1'b0, 2, -1, 1'b0, 1'b1);
    do_start(1'b0);
  endtask

  task automatic test_mid_reset();
    do_start(1'b0);
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0 || row !== 10'd0 ||
        col !== 10'd0 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL mid_reset: got we=%b busy=%b ready=%b row=%0d col=%0d pending=%0d, expected 0 0 0 0 0 0",
               mem_we, busy, pix_ready, row, col, exp_q.size());
    end
    step();
    do_start(1'b0);
    run_frame(1'b0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    do_start(1'b1);
    run_frame(1'b0, -1, 6, 1'b1, 1'b0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_addr  = 0;
    wr_cnt    = 0;
    done_cnt  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    pix_eol   = 1'b0;
    test_reset();
    test_back_to_back();
    test_valid_toggle();
    test_line_err();
    test_mid_reset();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
